blft: RTL and testbench

BLFT -- requirements
Module: blft

---
 rtl/blft_pkg.sv | 38 +++
 rtl/blft_div.sv | 56 +++++
 rtl/blft.sv | 138 +++++++++++++
 tb/tb_blft.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/blft_pkg.sv
// Shared constants, types and helpers for the 256x256 bilateral filter (blft).
package blft_pkg;

    localparam int IMG_W = 256;
    localparam int IMG_H = 256;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CNT_W = 17;

    // Centre of the 3x3 window trails the newest pushed pixel by one row plus one column.
    localparam logic [CNT_W-1:0] CENTRE_LAG = CNT_W'(IMG_W + 1);
    localparam logic [CNT_W-1:0] PUSH_END   = CNT_W'(NPIX + IMG_W + 1);

    localparam logic [2:0] SPATIAL [3][3] = '{'{3'd1, 3'd2, 3'd1},
                                              '{3'd2, 3'd4, 3'd2},
                                              '{3'd1, 3'd2, 3'd1}};

    localparam logic [7:0] RANGE_TH  [4] = '{8'd8, 8'd16, 8'd32, 8'd64};
    localparam logic [3:0] RANGE_VAL [5] = '{4'd8, 4'd4, 4'd2, 4'd1, 4'd0};

    typedef struct packed {
        logic        border;
        logic [7:0]  centre;
        logic [15:0] addr;
    } pix_tag_t;

    function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [3:0] range_w(input logic [7:0] d);
        logic [3:0] r;
        r = RANGE_VAL[4];
        for (int i = 3; i >= 0; i--)
            if (d < RANGE_TH[i]) r = RANGE_VAL[i];
        return r;
    endfunction

endpackage

// File: rtl/blft_div.sv
// Two-stage rounding divider: floor((num + floor(den/2)) / den), saturated to 255.
module blft_div
    import blft_pkg::*;
#(
    parameter int TAG_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [14:0]      num_i,
    input  logic [7:0]       den_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [7:0]       quot_o,
    output logic [TAG_W-1:0] tag_o
);

    logic [1:0]       vld_q;
    logic [15:0]      num_q;
    logic [7:0]       den_q;
    logic [TAG_W-1:0] tag1_q, tag2_q;
    logic [7:0]       quot_q, quot_d;
    logic [15:0]      q16;

    always_comb begin
        q16    = '0;
        quot_d = 8'hFF;
        if (den_q != 8'd0) begin
            q16    = num_q / {8'd0, den_q};
            quot_d = (q16 > 16'd255) ? 8'hFF : q16[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            num_q  <= '0;
            den_q  <= '0;
            tag1_q <= '0;
            tag2_q <= '0;
            quot_q <= '0;
        end else begin
            vld_q  <= {vld_q[0], valid_i};
            num_q  <= {1'b0, num_i} + {9'd0, den_i[7:1]};
            den_q  <= den_i;
            tag1_q <= tag_i;
            tag2_q <= tag1_q;
            quot_q <= quot_d;
        end
    end

    assign valid_o = vld_q[1];
    assign quot_o  = quot_q;
    assign tag_o   = tag2_q;

endmodule

// File: rtl/blft.sv
// 3x3 bilateral filter over a raster-order 256x256 frame using two line buffers.
// Range weighting is enabled by defining BLFT_RANGE_WEIGHT_EN; otherwise a pure Gaussian.
module blft
    import blft_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_addr,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    output logic [15:0] out_addr,
    output logic [7:0]  out_data,
    output logic        finish
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_acc, flush, push;
    logic [7:0]       px, col;
    logic [7:0]       lb1_q [IMG_W];
    logic [7:0]       lb2_q [IMG_W];
    logic [7:0]       win_q [3][3];
    logic             vld_a_q;
    logic [15:0]      addr_a_q;
    logic             out_valid_q, out_valid_d, finish_q, finish_d;
    logic [15:0]      out_addr_q, out_addr_d;
    logic [7:0]       out_data_q, out_data_d;

    // Inputs off the expected raster address are dropped; after the last pixel, phantom
    // pushes keep the window moving so the bottom border drains on consecutive cycles.
    assign in_acc = in_valid && !finish_q && !cnt_q[CNT_W-1] && (in_addr == cnt_q[15:0]);
    assign flush  = cnt_q[CNT_W-1] && (cnt_q < PUSH_END);
    assign push   = in_acc || flush;
    assign px     = in_acc ? in_data : 8'd0;
    assign col    = cnt_q[7:0];

    always_comb begin
        cnt_d = cnt_q;
        if (push) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            lb2_q[col] <= lb1_q[col];
            lb1_q[col] <= px;
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb2_q[col];
            win_q[1][2] <= lb1_q[col];
            win_q[2][2] <= px;
        end
    end

    logic [3:0]  rw;
    logic [5:0]  wt;
    logic [14:0] s_sum;
    logic [7:0]  w_sum;
    pix_tag_t    tag_a, tag_o;
    logic        div_vld;
    logic [7:0]  div_q;

    always_comb begin
        rw    = '0;
        wt    = '0;
        s_sum = '0;
        w_sum = '0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
`ifdef BLFT_RANGE_WEIGHT_EN
                rw = range_w(absdiff(win_q[r][k], win_q[1][1]));
`else
                rw = RANGE_VAL[0];
`endif
                wt    = 6'(SPATIAL[r][k]) * 6'(rw);
                s_sum = s_sum + 15'(wt) * 15'(win_q[r][k]);
                w_sum = w_sum + 8'(wt);
            end
        end
    end

    always_comb begin
        tag_a.addr   = addr_a_q;
        tag_a.centre = win_q[1][1];
        tag_a.border = (addr_a_q[15:8] == 8'd0) || (addr_a_q[15:8] == 8'hFF) ||
                       (addr_a_q[7:0]  == 8'd0) || (addr_a_q[7:0]  == 8'hFF);
    end

    blft_div #(.TAG_W($bits(pix_tag_t))) u_div (
        .clk     (clk),
        .rst     (rst),
        .valid_i (vld_a_q),
        .num_i   (s_sum),
        .den_i   (w_sum),
        .tag_i   (tag_a),
        .valid_o (div_vld),
        .quot_o  (div_q),
        .tag_o   (tag_o)
    );

    always_comb begin
        out_valid_d = div_vld;
        out_addr_d  = '0;
        out_data_d  = '0;
        finish_d    = finish_q || (out_valid_q && out_addr_q == 16'hFFFF);
        if (div_vld) begin
            out_addr_d = tag_o.addr;
            out_data_d = tag_o.border ? tag_o.centre : div_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            vld_a_q     <= 1'b0;
            addr_a_q    <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            finish_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            vld_a_q     <= push && (cnt_q >= CENTRE_LAG);
            addr_a_q    <= 16'(cnt_q - CENTRE_LAG);
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            finish_q    <= finish_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign finish    = finish_q;

endmodule

// File: tb/tb_blft.sv
// Bench for blft: aborted random frame, then a composite frame (flat, ramp, impulse,
// step, noise) checked pixel-by-pixel against a direct neighbourhood-sum model.
module tb_blft;

    logic        clk, rst, in_valid;
    logic [15:0] in_addr;
    logic [7:0]  in_data;
    logic        out_valid;
    logic [15:0] out_addr;
    logic [7:0]  out_data;
    logic        finish;

    blft dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .finish    (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] img  [65536];
    logic [7:0] expv [65536];
    int         acc_cyc [65536];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: weighted 3x3 mean straight from the filter definition.
    task automatic compute_exp();
        int a, s, w, ic, nv, sp, d, rg, q;
        for (int r = 0; r < 256; r++) begin
            for (int c = 0; c < 256; c++) begin
                a = r * 256 + c;
                if (r == 0 || r == 255 || c == 0 || c == 255) begin
                    expv[a] = img[a];
                end else begin
                    s  = 0;
                    w  = 0;
                    ic = int'(img[a]);
                    for (int dr = -1; dr <= 1; dr++) begin
                        for (int dc = -1; dc <= 1; dc++) begin
                            nv = int'(img[a + dr * 256 + dc]);
                            sp = (dr == 0 && dc == 0) ? 4 : ((dr == 0 || dc == 0) ? 2 : 1);
                            d  = (nv > ic) ? nv - ic : ic - nv;
`ifdef BLFT_RANGE_WEIGHT_EN
                            rg = (d < 8) ? 8 : (d < 16) ? 4 : (d < 32) ? 2 : (d < 64) ? 1 : 0;
`else
                            rg = 8 + (d & 0);
`endif
                            s += sp * rg * nv;
                            w += sp * rg;
                        end
                    end
                    q = (s + w / 2) / w;
                    if (q > 255) q = 255;
                    expv[a] = 8'(q);
                end
            end
        end
    endtask

    task automatic drive(input int n, input int gap);
        for (int a = 0; a < n; a++) begin
            if ($urandom_range(0, gap - 1) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid   = 1'b1;
            in_addr    = 16'(a);
            in_data    = img[a];
            acc_cyc[a] = cyc + 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_state();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_addr",  32'(out_addr),  32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_finish",    32'(finish),    32'd0);
    endtask

    // Output monitor: order, values, idle zeros, latency, flush continuity, finish timing.
    int nxt    = 0;
    int n_out  = 0;
    int last_a = -1;
    bit fin_exp = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            nxt     = 0;
            n_out   = 0;
            last_a  = -1;
            fin_exp = 1'b0;
        end else begin
            chk("finish", 32'(finish), 32'(fin_exp));
            if (last_a >= 65278 && last_a < 65535)
                chk("flush_consec", 32'(out_valid), 32'd1);
            if (out_valid) begin
                chk("out_order", 32'(out_addr), 32'(nxt));
                chk("out_data", 32'(out_data), 32'(expv[out_addr]));
                if (int'(out_addr) + 257 <= 65535)
                    chk("latency", 32'((cyc - acc_cyc[int'(out_addr) + 257]) <= 16), 32'd1);
                nxt++;
                n_out++;
                last_a = int'(out_addr);
                if (out_addr == 16'hFFFF) fin_exp = 1'b1;
            end else begin
                chk("idle_zero", {out_addr, 8'd0, out_data}, 32'd0);
            end
        end
    end

    initial begin
        int r, c;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state();

        // Frame 1: random pixels, heavy gaps, aborted part way through.
        for (int a = 0; a < 65536; a++) img[a] = 8'($urandom_range(0, 255));
        compute_exp();
        rst = 1'b0;
        drive(3000, 4);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_progress", 32'(n_out > 2000), 32'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state();

        // Frame 2: composite scene exercising each filter behaviour in its own band.
        for (int a = 0; a < 65536; a++) begin
            r = a / 256;
            c = a % 256;
            if (r < 40)       img[a] = 8'd100;
            else if (r < 80)  img[a] = 8'(c);
            else if (r < 120) img[a] = (r == 100 && c == 100) ? 8'd255 : 8'd0;
            else if (r < 160) img[a] = (c < 128) ? 8'd0 : 8'd200;
            else if (r < 208) img[a] = 8'($urandom_range(0, 255));
            else              img[a] = 8'(100 + $urandom_range(0, 40));
        end
        compute_exp();
        rst = 1'b0;
        @(posedge clk); #1;
        drive(65536, 32);

        for (int i = 0; i < 2000 && !finish; i++) @(posedge clk);
        #1;
        chk("finish_timeout", 32'(finish), 32'd1);
        chk("out_count", 32'(n_out), 32'd65536);

        // Traffic after finish must be ignored and finish must hold.
        in_valid = 1'b1;
        in_addr  = 16'd0;
        in_data  = 8'd7;
        repeat (6) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("finish_hold", 32'(finish), 32'd1);
        chk("post_finish_count", 32'(n_out), 32'd65536);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
